// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state encodings and default datapath width for the memory port arbiter
package mips_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY0 = 2'd1;
    localparam logic [1:0] ST_BUSY1 = 2'd2;

    localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// rtl/mem_port_arbiter_mux2.sv - WIDTH-bit two-input mux feeding the shared memory port
module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic             s_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = s_i ? d1_i : d0_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] addr0_i,
    input  logic [WIDTH-1:0] addr1_i,
    input  logic [WIDTH-1:0] wdata0_i,
    input  logic [WIDTH-1:0] wdata1_i,
    input  logic             we0_i,
    input  logic             we1_i,
    input  logic             mem_ready_i,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic             mem_valid_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    output logic             mem_we_o,
    output logic             sel_o,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             done0_o,
    output logic             done1_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             timeout_err_o
);
    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic             mem_valid_q, mem_valid_d;
    logic             timeout_err_q, timeout_err_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner;

    assign owner = (state_q == ST_BUSY1);

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        sel_d         = sel_q;
        gnt0_d        = gnt0_q;
        gnt1_d        = gnt1_q;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        mem_valid_d   = mem_valid_q;
        timeout_err_d = timeout_err_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // The done cycle is not an arbitration slot: the owner may still be holding req.
                if (!(done0_q || done1_q)) begin
                    if (req0_i && (!req1_i || last_q)) begin
                        state_d     = ST_BUSY0;
                        sel_d       = 1'b0;
                        gnt0_d      = 1'b1;
                        mem_valid_d = 1'b1;
                        cnt_d       = '0;
                    end else if (req1_i) begin
                        state_d     = ST_BUSY1;
                        sel_d       = 1'b1;
                        gnt1_d      = 1'b1;
                        mem_valid_d = 1'b1;
                        cnt_d       = '0;
                    end
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (mem_ready_i || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    if (mem_ready_i) begin
                        rdata_d = mem_rdata_i;
                    end else begin
                        timeout_err_d = 1'b1;
                    end
                    done0_d     = !owner;
                    done1_d     = owner;
                    gnt0_d      = 1'b0;
                    gnt1_d      = 1'b0;
                    mem_valid_d = 1'b0;
                    last_d      = owner;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt0_d      = 1'b0;
                gnt1_d      = 1'b0;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            last_q        <= 1'b1;
            sel_q         <= 1'b0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            mem_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            rdata_q       <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            sel_q         <= sel_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            mem_valid_q   <= mem_valid_d;
            timeout_err_q <= timeout_err_d;
            rdata_q       <= rdata_d;
            cnt_q         <= cnt_d;
        end
    end

    mux2 #(.WIDTH(WIDTH)) u_addr_mux (
        .d0_i (addr0_i),
        .d1_i (addr1_i),
        .s_i  (sel_q),
        .y_o  (mem_addr_o)
    );

    mux2 #(.WIDTH(WIDTH)) u_wdata_mux (
        .d0_i (wdata0_i),
        .d1_i (wdata1_i),
        .s_i  (sel_q),
        .y_o  (mem_wdata_o)
    );

    assign mem_we_o      = (sel_q ? we1_i : we0_i) & mem_valid_q;
    assign mem_valid_o   = mem_valid_q;
    assign sel_o         = sel_q;
    assign gnt0_o        = gnt0_q;
    assign gnt1_o        = gnt1_q;
    assign done0_o       = done0_q;
    assign done1_o       = done1_q;
    assign rdata_o       = rdata_q;
    assign timeout_err_o = timeout_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with directed accesses
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1, mem_ready;
    logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
    logic        mem_valid, mem_we, sel, gnt0, gnt1, done0, done1, timeout_err;
    logic [31:0] mem_addr, mem_wdata, rdata;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        terr;
    } exp_t;

    exp_t        sb[$];
    int          done_cyc[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        resp_en = 1'b0;
    int          resp_delay = 0;
    int          vcnt = 0;
    logic        idle_pulse = 1'b0;
    logic [31:0] rd0 = '0, rd1 = '0;

    mem_port_arbiter dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .req0_i        (req0),
        .req1_i        (req1),
        .addr0_i       (addr0),
        .addr1_i       (addr1),
        .wdata0_i      (wdata0),
        .wdata1_i      (wdata1),
        .we0_i         (we0),
        .we1_i         (we1),
        .mem_ready_i   (mem_ready),
        .mem_rdata_i   (mem_rdata),
        .mem_valid_o   (mem_valid),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_we_o      (mem_we),
        .sel_o         (sel),
        .gnt0_o        (gnt0),
        .gnt1_o        (gnt1),
        .done0_o       (done0),
        .done1_o       (done1),
        .rdata_o       (rdata),
        .timeout_err_o (timeout_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: answers after resp_delay BUSY cycles, or pulses ready while idle on request.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rdata = idle_pulse ? 32'hFFFF_FFFF : (sel ? rd1 : rd0);
            if (mem_valid) begin
                mem_ready = resp_en && (vcnt >= resp_delay);
                vcnt = mem_ready ? 0 : vcnt + 1;
            end else begin
                mem_ready = idle_pulse;
                vcnt = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && (done0 || done1)) begin
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_done", {done1, done0}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_port", {done1, done0}, e.port ? 2'b10 : 2'b01);
                chk("done_rdata", rdata, e.rdata);
                chk("done_terr", timeout_err, e.terr);
            end
        end
    end

    task automatic run_single(input logic port, input logic [31:0] a, input logic [31:0] wd,
                              input logic we, input logic en, input int dly,
                              input logic [31:0] rdv, input logic [31:0] exp_rd,
                              input logic exp_terr, output int busy_n);
        bit seen = 0;
        resp_en = en;
        resp_delay = dly;
        rd0 = rdv;
        rd1 = rdv;
        sb.push_back('{port: port, rdata: exp_rd, terr: exp_terr});
        @(posedge clk); #1;
        if (port) begin
            addr1 = a; wdata1 = wd; we1 = we; req1 = 1'b1;
        end else begin
            addr0 = a; wdata0 = wd; we0 = we; req0 = 1'b1;
        end
        @(negedge clk);
        chk("latency_idle_valid", mem_valid, 1'b0);
        @(negedge clk);
        chk("busy_valid", mem_valid, 1'b1);
        chk("busy_sel", sel, port);
        chk("busy_gnt", {gnt1, gnt0}, port ? 2'b10 : 2'b01);
        chk("busy_addr", mem_addr, a);
        chk("busy_wdata", mem_wdata, wd);
        chk("busy_we", mem_we, we);
        busy_n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_valid) busy_n++;
            if (port ? done1 : done0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 1'b0, 1'b1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        bit ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("scoreboard_drain", sb.size(), 0);
    endtask

    initial begin
        int busy_n;
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {mem_valid, sel, gnt0, gnt1, done0, done1, timeout_err}, 7'b0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_single(1'b0, 32'h0040_0000, 32'h0, 1'b0, 1'b1, 1, 32'h8C08_0004, 32'h8C08_0004, 1'b0, busy_n);
        chk("t1_busy_cycles", busy_n, 2);

        we1 = 1'b1;
        run_single(1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 2, 32'h1234_5678, 32'h1234_5678, 1'b0, busy_n);
        @(negedge clk);
        chk("t3_we_after_done", mem_we, 1'b0);
        we1 = 1'b0;

        run_single(1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 0, 32'h0, 32'h1234_5678, 1'b1, busy_n);
        chk("t4_busy_cycles", busy_n, 16);
        chk("t4_terr", timeout_err, 1'b1);

        run_single(1'b1, 32'h1001_0004, 32'h0, 1'b0, 1'b1, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1, busy_n);
        chk("sticky_terr", timeout_err, 1'b1);

        @(posedge clk); #1;
        idle_pulse = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("t6_rdata", rdata, 32'h0BAD_F00D);
            chk("t6_idle", {mem_valid, gnt0, gnt1}, 3'b0);
        end
        idle_pulse = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("t6_still_idle", {mem_valid, gnt0, gnt1, done0, done1}, 5'b0);

        resp_en = 1'b0;
        @(posedge clk); #1;
        req1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_gnt1", gnt1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_outputs", {mem_valid, sel, gnt0, gnt1, done0, done1, timeout_err}, 7'b0);
        chk("t5_async_rdata", rdata, 32'h0);
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        rd0 = 32'h0000_1111;
        rd1 = 32'h0000_2222;
        resp_en = 1'b1;
        resp_delay = 0;
        done_cyc.delete();
        sb.push_back('{port: 1'b0, rdata: 32'h0000_1111, terr: 1'b0});
        sb.push_back('{port: 1'b1, rdata: 32'h0000_2222, terr: 1'b0});
        sb.push_back('{port: 1'b0, rdata: 32'h0000_1111, terr: 1'b0});
        sb.push_back('{port: 1'b1, rdata: 32'h0000_2222, terr: 1'b0});
        @(posedge clk); #1;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_empty(40);
        req0 = 1'b0;
        req1 = 1'b0;
        chk("t2_done_count", done_cyc.size(), 4);
        if (done_cyc.size() == 4) begin
            for (int i = 0; i < 3; i++) chk("t2_done_period", done_cyc[i+1] - done_cyc[i], 3);
        end
        repeat (4) @(negedge clk);
        #1;
        chk("final_idle", {mem_valid, gnt0, gnt1}, 3'b0);
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
